// File: rtl/fpu_pkg.sv
// Shared constants for the x87-style FPU slice: opcodes, FSM encoding,
// special operand values and operand classification helpers.
package fpu_pkg;

    localparam logic [7:0] OP_FLD  = 8'h20;
    localparam logic [7:0] OP_FST  = 8'h22;
    localparam logic [7:0] OP_FCOM = 8'h60;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_STACK_OP  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [79:0] FP_INDEFINITE = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [15:0] CTRL_RESET    = 16'h037F;

    function automatic logic is_nan(input logic [79:0] v);
        return (v[78:64] == 15'h7FFF) && (v[62:0] != '0);
    endfunction

endpackage

// File: rtl/fpu_compare80.sv
// Combinational ordered/unordered compare of two 80-bit extended reals.
module fpu_compare80
    import fpu_pkg::*;
(
    input  logic [79:0] a,
    input  logic [79:0] b,
    output logic        cc_equal,
    output logic        cc_less,
    output logic        cc_greater,
    output logic        cc_unordered
);

    logic nan;
    logic both_zero;
    logic a_mag_gt;

    always_comb begin
        cc_equal     = 1'b0;
        cc_less      = 1'b0;
        cc_greater   = 1'b0;
        cc_unordered = 1'b0;
        nan       = is_nan(a) || is_nan(b);
        both_zero = (a[78:0] == '0) && (b[78:0] == '0);
        a_mag_gt  = a[78:0] > b[78:0];
        if (nan) begin
            cc_unordered = 1'b1;
        end else if (both_zero || (a == b)) begin
            cc_equal = 1'b1;
        end else if (a[79] != b[79]) begin
            cc_greater = !a[79];
            cc_less    = a[79];
        end else begin
            // same sign: magnitude order flips for negatives
            cc_greater = a_mag_gt ^ a[79];
            cc_less    = !(a_mag_gt ^ a[79]);
        end
    end

endmodule

// File: rtl/fpu_core.sv
// Sequenced x87-style core: 8-entry register stack with FLD, FST and FCOM.
module fpu_core
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        execute,
    input  logic [7:0]  instruction,
    input  logic [2:0]  stack_index,
    input  logic [79:0] data_in,
    input  logic [31:0] int_data_in,
    input  logic [15:0] control_in,
    input  logic        control_write,
    output logic        ready,
    output logic        error,
    output logic [79:0] data_out,
    output logic [15:0] status_out
);

    logic [2:0]  state;
    logic [7:0]  current_inst;
    logic [2:0]  index;
    logic [79:0] operand;
    logic [79:0] regs [8];
    logic [7:0]  tags;
    logic [2:0]  top;
    logic [15:0] control;
    logic        c3, c2, c1, c0;
    logic        es, sf, ie;
    logic [79:0] temp_operand_a;
    logic [79:0] temp_operand_b;
    logic [79:0] temp_result;
    logic        valid_a, valid_b, tgt_valid;
    logic        exc_ie, exc_sf;
    logic [3:0]  res_cc;
    logic [79:0] st0;
    logic [79:0] stack_read_data;
    logic        stack_push;
    logic        stack_write_enable;
    logic [2:0]  stack_write_reg;
    logic [79:0] stack_data_in;
    logic        arith_done;
    logic        arith_cc_equal;
    logic        arith_cc_less;
    logic        arith_cc_greater;
    logic        arith_cc_unordered;
    logic        is_fld, is_fst, is_fcom;
    logic [2:0]  src_reg, push_reg;
    logic        int_data_unused;
    logic        ctrl_unused;

    assign int_data_unused = ^int_data_in;
    assign ctrl_unused     = ^control[15:1];

    assign src_reg  = top + index;
    assign push_reg = top - 3'd1;

    assign st0             = regs[top];
    assign stack_read_data = regs[src_reg];

    assign is_fld  = current_inst == OP_FLD;
    assign is_fst  = current_inst == OP_FST;
    assign is_fcom = current_inst == OP_FCOM;

    assign arith_done         = state == S_EXECUTE;
    assign stack_push         = (state == S_STACK_OP) && is_fld;
    assign stack_write_enable = stack_push;
    assign stack_write_reg    = push_reg;
    assign stack_data_in      = temp_result;

    assign ready      = state == S_DONE;
    assign error      = es;
    assign status_out = {1'b0, c3, top, c2, c1, c0,
                         es, sf, 5'b0, ie};

    fpu_compare80 u_cmp (
        .a            (temp_operand_a),
        .b            (temp_operand_b),
        .cc_equal     (arith_cc_equal),
        .cc_less      (arith_cc_less),
        .cc_greater   (arith_cc_greater),
        .cc_unordered (arith_cc_unordered)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            current_inst   <= '0;
            index          <= '0;
            operand        <= '0;
            tags           <= '0;
            top            <= '0;
            control        <= CTRL_RESET;
            {c3, c2, c1, c0} <= '0;
            {es, sf, ie}   <= '0;
            data_out       <= '0;
            temp_operand_a <= '0;
            temp_operand_b <= '0;
            {valid_a, valid_b, tgt_valid} <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (control_write) control <= control_in;
            unique case (state)
                S_IDLE: begin
                    if (execute) begin
                        current_inst <= instruction;
                        index        <= stack_index;
                        operand      <= data_in;
                        state        <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    temp_operand_a <= st0;
                    temp_operand_b <= stack_read_data;
                    valid_a        <= tags[top];
                    valid_b        <= tags[src_reg];
                    tgt_valid      <= tags[push_reg];
                    state          <= S_EXECUTE;
                end
                S_EXECUTE: state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    {c3, c2, c1, c0} <= res_cc;
                    ie    <= ie | exc_ie;
                    sf    <= sf | exc_sf;
                    es    <= es | ((ie | exc_ie) & ~control[0]);
                    state <= S_STACK_OP;
                end
                S_STACK_OP: begin
                    if (stack_write_enable) begin
                        regs[stack_write_reg] <= stack_data_in;
                        tags[stack_write_reg] <= 1'b1;
                    end
                    if (stack_push) top <= push_reg;
                    if (is_fst) data_out <= temp_result;
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // result and flags are staged here, committed in WRITEBACK/STACK_OP
    always_ff @(posedge clk) begin
        if (arith_done) begin
            temp_result <= temp_operand_a;
            exc_ie      <= 1'b0;
            exc_sf      <= 1'b0;
            res_cc      <= 4'b0000;
            unique case (1'b1)
                is_fld: begin
                    temp_result <= tgt_valid ? FP_INDEFINITE : operand;
                    exc_ie      <= tgt_valid;
                    exc_sf      <= tgt_valid;
                    res_cc      <= {2'b00, tgt_valid, 1'b0};
                end
                is_fst: begin
                    if (!valid_a) temp_result <= FP_INDEFINITE;
                    exc_ie <= !valid_a;
                    exc_sf <= !valid_a;
                end
                is_fcom: begin
                    if (!(valid_a && valid_b)) begin
                        res_cc <= 4'b1101;
                        exc_ie <= 1'b1;
                        exc_sf <= 1'b1;
                    end else begin
                        unique case (1'b1)
                            arith_cc_unordered: begin
                                res_cc <= 4'b1101;
                                exc_ie <= 1'b1;
                            end
                            arith_cc_greater: res_cc <= 4'b0000;
                            arith_cc_less:    res_cc <= 4'b0001;
                            arith_cc_equal:   res_cc <= 4'b1000;
                            default:          res_cc <= 4'b1101;
                        endcase
                    end
                end
                default: exc_ie <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_core.sv
// Scoreboard bench for fpu_core: a behavioural stack model predicts each
// completion; scenario tasks add direct checks on condition codes and TOP.
module tb_fpu_core;

    localparam logic [79:0] INDEF = 80'hFFFF_C000_0000_0000_0000;
    localparam logic [79:0] ONE   = 80'h3FFF_8000_0000_0000_0000;
    localparam logic [79:0] TWO   = 80'h4000_8000_0000_0000_0000;
    localparam logic [79:0] MONE  = 80'hBFFF_8000_0000_0000_0000;
    localparam logic [79:0] PZERO = 80'h0;
    localparam logic [79:0] NZERO = 80'h8000_0000_0000_0000_0000;
    localparam logic [79:0] QNAN  = 80'h7FFF_C000_0000_0000_0001;
    localparam logic [79:0] INF   = 80'h7FFF_8000_0000_0000_0000;
    localparam logic [79:0] DEN   = 80'h0000_0000_0000_0000_0001;

    logic        clk = 1'b0;
    logic        reset, execute, control_write;
    logic [7:0]  instruction;
    logic [2:0]  stack_index;
    logic [79:0] data_in;
    logic [31:0] int_data_in;
    logic [15:0] control_in;
    logic        ready, error;
    logic [79:0] data_out;
    logic [15:0] status_out;

    always #5 clk = ~clk;

    fpu_core dut (
        .clk           (clk),
        .reset         (reset),
        .execute       (execute),
        .instruction   (instruction),
        .stack_index   (stack_index),
        .data_in       (data_in),
        .int_data_in   (int_data_in),
        .control_in    (control_in),
        .control_write (control_write),
        .ready         (ready),
        .error         (error),
        .data_out      (data_out),
        .status_out    (status_out)
    );

    typedef struct {
        logic [15:0] status;
        logic [79:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [79:0] m_reg [8];
    logic [7:0]  m_tag;
    logic [2:0]  m_top;
    logic        m_c3, m_c2, m_c1, m_c0, m_ie, m_sf, m_es;
    logic [15:0] m_ctrl;
    logic [79:0] m_out;

    function automatic logic m_nan(input logic [79:0] v);
        return v[78:64] == 15'h7FFF && v[62:0] != 63'd0;
    endfunction

    // signed integer key: negatives map below zero, so -0 == +0
    function automatic logic signed [80:0] m_key(input logic [79:0] v);
        logic signed [80:0] k;
        k = $signed({2'b00, v[78:0]});
        return v[79] ? -k : k;
    endfunction

    function automatic logic [15:0] m_status();
        return {1'b0, m_c3, m_top, m_c2, m_c1, m_c0,
                m_es, m_sf, 5'b0, m_ie};
    endfunction

    function automatic logic [2:0] cc();
        return {status_out[14], status_out[10], status_out[8]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_tag = '0;
        m_top = '0;
        {m_c3, m_c2, m_c1, m_c0} = 4'b0;
        {m_ie, m_sf, m_es} = 3'b0;
        m_ctrl = 16'h037F;
        m_out = '0;
    endtask

    task automatic model_exec(input logic [7:0] op, input logic [2:0] idx,
                              input logic [79:0] d);
        logic [2:0]         t;
        logic [79:0]        a, b;
        logic signed [80:0] ka, kb;
        case (op)
            8'h20: begin
                t = m_top - 3'd1;
                {m_c3, m_c2, m_c0} = 3'b000;
                m_c1 = m_tag[t];
                if (m_tag[t]) begin
                    m_ie = 1'b1; m_sf = 1'b1; m_reg[t] = INDEF;
                end else begin
                    m_reg[t] = d;
                end
                m_tag[t] = 1'b1;
                m_top = t;
            end
            8'h22: begin
                {m_c3, m_c2, m_c1, m_c0} = 4'b0;
                if (m_tag[m_top]) m_out = m_reg[m_top];
                else begin
                    m_out = INDEF; m_ie = 1'b1; m_sf = 1'b1;
                end
            end
            8'h60: begin
                m_c1 = 1'b0;
                t = m_top + idx;
                a = m_reg[m_top];
                b = m_reg[t];
                if (!m_tag[m_top] || !m_tag[t]) begin
                    {m_c3, m_c2, m_c0} = 3'b111;
                    m_ie = 1'b1; m_sf = 1'b1;
                end else if (m_nan(a) || m_nan(b)) begin
                    {m_c3, m_c2, m_c0} = 3'b111;
                    m_ie = 1'b1;
                end else begin
                    ka = m_key(a);
                    kb = m_key(b);
                    if (ka > kb)      {m_c3, m_c2, m_c0} = 3'b000;
                    else if (ka < kb) {m_c3, m_c2, m_c0} = 3'b001;
                    else              {m_c3, m_c2, m_c0} = 3'b100;
                end
            end
            default: begin
                {m_c3, m_c2, m_c1, m_c0} = 4'b0;
                m_ie = 1'b1;
            end
        endcase
        if (m_ie && !m_ctrl[0]) m_es = 1'b1;
    endtask

    // completion monitor: pops one prediction per ready pulse
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_ready at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL ready_latency cycle %0d want %0d",
                             cyc, mon_e.due);
                end
                checks++;
                if (status_out !== mon_e.status) begin
                    errors++;
                    $display("FAIL status got %h want %h",
                             status_out, mon_e.status);
                end
                checks++;
                if (data_out !== mon_e.data) begin
                    errors++;
                    $display("FAIL data_out got %h want %h",
                             data_out, mon_e.data);
                end
                checks++;
                if (error !== mon_e.err) begin
                    errors++;
                    $display("FAIL error got %b want %b", error, mon_e.err);
                end
            end
        end
    end

    task automatic start_inst(input logic [7:0] op, input logic [2:0] idx,
                              input logic [79:0] d, input int hold);
        exp_t e;
        @(negedge clk);
        execute = 1'b1; instruction = op;
        stack_index = idx; data_in = d;
        @(posedge clk);
        e.due = cyc + 5;
        model_exec(op, idx, d);
        e.status = m_status();
        e.data = m_out;
        e.err = m_es;
        sb.push_back(e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            instruction = 8'h20; data_in = ~d; stack_index = ~idx;
            @(posedge clk);
        end
        @(negedge clk);
        execute = 1'b0; instruction = 8'h00;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] idx,
                         input logic [79:0] d);
        start_inst(op, idx, d, 0);
        wait_done();
    endtask

    task automatic write_ctrl(input logic [15:0] v);
        @(negedge clk);
        control_write = 1'b1; control_in = v;
        @(negedge clk);
        control_write = 1'b0;
        m_ctrl = v;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; execute = 1'b0; control_write = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (status_out !== 16'h0000) begin
            errors++; $display("FAIL reset_status got %h want 0000", status_out);
        end
        checks++;
        if (ready !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL reset_flags got %b%b want 00", ready, error);
        end
        checks++;
        if (data_out !== 80'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", data_out);
        end
        issue(8'h22, 3'd0, '0);
        checks++;
        if (data_out !== INDEF || status_out[9] !== 1'b0) begin
            errors++;
            $display("FAIL fst_empty got %h c1=%b want %h c1=0",
                     data_out, status_out[9], INDEF);
        end
    endtask

    task automatic test_fcom_greater();
        do_reset();
        issue(8'h20, 3'd0, ONE);
        issue(8'h20, 3'd0, TWO);
        issue(8'h60, 3'd1, '0);
        checks++;
        if (cc() !== 3'b000) begin
            errors++; $display("FAIL fcom_gt_cc got %b want 000", cc());
        end
        checks++;
        if (status_out[13:11] !== 3'd6) begin
            errors++; $display("FAIL fcom_gt_top got %0d want 6", status_out[13:11]);
        end
    endtask

    task automatic test_fcom_less_equal();
        do_reset();
        issue(8'h20, 3'd0, TWO);
        issue(8'h20, 3'd0, ONE);
        issue(8'h60, 3'd1, '0);
        checks++;
        if (cc() !== 3'b001) begin
            errors++; $display("FAIL fcom_lt_cc got %b want 001", cc());
        end
        issue(8'h60, 3'd0, '0);
        checks++;
        if (cc() !== 3'b100) begin
            errors++; $display("FAIL fcom_eq_cc got %b want 100", cc());
        end
    endtask

    task automatic test_zero_nan();
        do_reset();
        issue(8'h20, 3'd0, PZERO);
        issue(8'h20, 3'd0, NZERO);
        issue(8'h60, 3'd1, '0);
        checks++;
        if (cc() !== 3'b100) begin
            errors++; $display("FAIL signed_zero_cc got %b want 100", cc());
        end
        issue(8'h20, 3'd0, QNAN);
        issue(8'h60, 3'd1, '0);
        checks++;
        if (cc() !== 3'b111 || status_out[0] !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL nan_masked cc=%b ie=%b err=%b want 111 1 0",
                     cc(), status_out[0], error);
        end
    endtask

    task automatic test_unmasked_empty();
        do_reset();
        write_ctrl(16'h037E);
        issue(8'h60, 3'd1, '0);
        checks++;
        if (cc() !== 3'b111 || status_out[0] !== 1'b1 ||
            status_out[6] !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL empty_unmasked cc=%b ie=%b sf=%b err=%b want 111 1 1 1",
                     cc(), status_out[0], status_out[6], error);
        end
    endtask

    task automatic test_overflow();
        logic [79:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            v = {16'h3FFF, 64'h8000_0000_0000_0000 | 64'(i)};
            issue(8'h20, 3'd0, v);
        end
        checks++;
        if (status_out[0] !== 1'b0 || status_out[13:11] !== 3'd0) begin
            errors++;
            $display("FAIL eight_fld ie=%b top=%0d want 0 0",
                     status_out[0], status_out[13:11]);
        end
        issue(8'h22, 3'd0, '0);
        checks++;
        if (data_out !== {16'h3FFF, 64'h8000_0000_0000_0008}) begin
            errors++; $display("FAIL fst_top got %h want 3fff8000000000000008", data_out);
        end
        issue(8'h20, 3'd0, ONE);
        checks++;
        if (status_out[0] !== 1'b1 || status_out[6] !== 1'b1 ||
            status_out[9] !== 1'b1 || status_out[13:11] !== 3'd7) begin
            errors++;
            $display("FAIL overflow ie=%b sf=%b c1=%b top=%0d want 1 1 1 7",
                     status_out[0], status_out[6], status_out[9],
                     status_out[13:11]);
        end
        issue(8'h22, 3'd0, '0);
        checks++;
        if (data_out !== INDEF) begin
            errors++; $display("FAIL overflow_fst got %h want %h", data_out, INDEF);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(8'h20, 3'd0, ONE);
        issue(8'h22, 3'd0, '0);
        issue(8'h60, 3'd0, '0);
        issue(8'h55, 3'd0, TWO);
        checks++;
        if (status_out[0] !== 1'b1 || status_out[13:11] !== 3'd7 ||
            data_out !== ONE) begin
            errors++;
            $display("FAIL bad_opcode ie=%b top=%0d data=%h want 1 7 %h",
                     status_out[0], status_out[13:11], data_out, ONE);
        end
    endtask

    task automatic test_execute_ignored();
        do_reset();
        start_inst(8'h20, 3'd0, TWO, 4);
        wait_done();
        repeat (3) @(negedge clk);
        checks++;
        if (status_out[13:11] !== 3'd7 || status_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL exec_busy top=%0d ie=%b want 7 0",
                     status_out[13:11], status_out[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        issue(8'h20, 3'd0, ONE);
        start_inst(8'h20, 3'd0, TWO, 0);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        checks++;
        if (status_out !== 16'h0000 || ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset status=%h ready=%b want 0000 0",
                     status_out, ready);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL mid_reset_pulse got %0d want 0", seen);
        end
        issue(8'h22, 3'd0, '0);
    endtask

    task automatic test_random();
        logic [79:0] tbl [8];
        int          k;
        logic [7:0]  op;
        tbl[0] = ONE;  tbl[1] = TWO;   tbl[2] = MONE; tbl[3] = PZERO;
        tbl[4] = NZERO; tbl[5] = QNAN; tbl[6] = INF;  tbl[7] = DEN;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            op = (k < 4) ? 8'h20 : (k < 8) ? 8'h60 : (k == 8) ? 8'h22 : 8'h7E;
            issue(op, 3'($urandom_range(0, 7)), tbl[$urandom_range(0, 7)]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; execute = 1'b0; control_write = 1'b0;
        instruction = '0; stack_index = '0; data_in = '0;
        int_data_in = 32'hDEAD_BEEF; control_in = '0;
        model_reset();
        test_reset();
        test_fcom_greater();
        test_fcom_less_equal();
        test_zero_nan();
        test_unmasked_empty();
        test_overflow();
        test_back_to_back();
        test_execute_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_core.md
FPU_CORE -- requirements
Module: fpu_core

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 execute  in  1  start request; sampled only in IDLE.
REQ-005 instruction  in  8  opcode: 0x20 FLD, 0x22 FST, 0x60 FCOM.
REQ-006 stack_index  in  3  i for ST(i); used by FCOM only.
REQ-007 data_in  in  80  extended-real operand for FLD (sign[79], exp[78:64], mantissa[63:0] with explicit integer bit).
REQ-008 int_data_in  in  32  reserved; ignored.
REQ-009 control_in  in  16  new control word.
REQ-010 control_write  in  1  loads control_in into the control register at the next edge; accepted in any state.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 error  out  1  status ES bit (status[7]).
REQ-013 data_out  out  80  FST result; held until the next FST.
REQ-014 status_out  out  16  status word.

Function
REQ-015 Status bits SHALL be: B[15]=0, C3[14], TOP[13:11], C2[10], C1[9], C0[8], ES[7], SF[6], IE[0]; all other bits SHALL be 0.
REQ-016 The register file SHALL be 8 x 80-bit registers with one empty/valid tag each; ST(i) = R[(TOP+i) mod 8].
REQ-017 State sequence SHALL be IDLE -> DECODE -> EXECUTE -> WRITEBACK -> STACK_OP -> DONE -> IDLE, one cycle per state.
REQ-018 In IDLE with execute=1 at an edge, the block SHALL latch instruction, stack_index and data_in (into current_inst, index and operand registers) and go to DECODE.
REQ-019 In DECODE the block SHALL read ST(0) and ST(stack_index) into temp_operand_a and temp_operand_b.
REQ-020 In EXECUTE the block SHALL compute the result and condition codes; the comparator SHALL be combinational, so arith_done is high in this cycle.
REQ-021 WRITEBACK SHALL update status; STACK_OP SHALL perform stack writes and TOP changes.
REQ-022 ready SHALL be 1 only during DONE, i.e. exactly the 5th cycle after the accepting edge; status_out and data_out SHALL be final when ready=1.
REQ-023 execute SHALL be ignored outside IDLE.
REQ-024 FLD SHALL set TOP=(TOP-1) mod 8 (wrap-around 0->7), write data_in to the new ST(0), tag it valid, and set C1=0.
REQ-025 FLD overflow: if the target register is already valid, the block SHALL set IE=1, SF=1, C1=1 and load the indefinite 0xFFFF_C000000000000000.
REQ-026 FST SHALL drive data_out=ST(0) and leave the stack unchanged.
REQ-027 FST with an empty ST(0) SHALL set IE=1, SF=1, C1=0 and output the indefinite.
REQ-028 FCOM SHALL compare ST(0) with ST(stack_index), leave the stack unchanged, and set C1=0 with (C3,C2,C0):
- ST0>src: 000
- ST0<src: 001
- equal: 100
- unordered: 111
REQ-029 Comparison SHALL be by sign, then exponent, then mantissa, with magnitude order reversed for negative operands.
REQ-030 +0 and -0 SHALL compare equal.
REQ-031 NaN (exp=0x7FFF, mantissa[62:0]!=0) in either operand SHALL give unordered and set IE=1.
REQ-032 FCOM with either operand empty SHALL give 111 and set IE=1, SF=1.
REQ-033 Any other opcode SHALL set IE=1, with no stack or data_out change, and still complete with a ready pulse.
REQ-034 ES SHALL be set when IE=1 and control bit0 (IM)=0; error SHALL equal ES.
REQ-035 IE, SF and ES SHALL be sticky until reset; condition codes SHALL be overwritten by each instruction.

Reset
REQ-036 On reset, including mid-instruction, the block SHALL go to IDLE and set: all tags empty, TOP=0, status=0x0000, control=0x037F, ready=0, error=0, data_out=0, registers=0.

Structure
REQ-037 Package fpu_pkg SHALL hold the opcode constants, the state encoding, the indefinite value and the reset control word.
REQ-038 Sub-module fpu_compare80 SHALL take two 80-bit operands and output cc_equal, cc_less, cc_greater and cc_unordered.
REQ-039 The core SHALL name its internal signals state, current_inst, st0, stack_read_data, temp_operand_a/b, temp_result, stack_push, stack_write_enable, stack_write_reg, stack_data_in, arith_done and arith_cc_*.

Verification
REQ-040 FLD 1.0 (0x3FFF_8000000000000000), then FLD 2.0 (0x4000_8000000000000000), then FCOM i=1 -> C3,C2,C0=000, TOP=6.
REQ-041 FLD 2.0, FLD 1.0, FCOM i=1 -> 001; FCOM i=0 -> 100.
REQ-042 FLD +0, FLD -0 (0x8000_0...), FCOM i=1 -> 100; FLD NaN 0x7FFF_C000000000000001 then FCOM -> 111, IE=1, error=0 (masked).
REQ-043 control_write 0x037E, then FCOM on an empty stack -> 111, IE=1, SF=1, error=1.
REQ-044 Nine FLDs -> 9th sets IE, SF, C1=1 and TOP wraps to 7; FST then gives data_out = indefinite.
REQ-045 Assert reset during EXECUTE -> next cycle IDLE, status=0, ready=0, no ready pulse; ready pulse exactly 5 cycles after accept for every opcode.
